univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised WIDTH-bit edge-triggered register: the multi-bit, multi-mode successor to the single-bit D storage cell.
//  Supports hold, parallel load, shift, rotate, sync clear and counted serial-in with a completion pulse.
//  Sits between serial links and parallel datapaths as a SIPO/PISO/general-purpose staging register.
// PARAMETERS
//  WIDTH      8      register width in bits, >= 2
//  RESET_VAL  0      value of Q on async reset and on sync CLEAR, WIDTH bits
// PORTS
//  clk    in   1      clock, rising edge active
//  rst_n  in   1      asynchronous reset, active low
//  E      in   1      enable; 0 = hold everything, including the serial counter
//  MODE   in   3      operation select, sampled when E=1
//  D      in   WIDTH  parallel load data
//  SI_L   in   1      serial input entering at MSB (SHR, SER_IN)
//  SI_R   in   1      serial input entering at LSB (SHL)
//  Q      out  WIDTH  register contents
//  Qbar   out  WIDTH  ~Q, always the exact complement
//  SO_L   out  1      Q[WIDTH-1], combinational from Q
//  SO_R   out  1      Q[0], combinational from Q
//  DONE   out  1      one-cycle pulse, serial word complete
// BEHAVIOUR
//  Reset: rst_n=0 -> immediately Q=RESET_VAL, Qbar=~RESET_VAL, DONE=0, cnt=0, independent of clk.
//  Release of rst_n: first active edge afterwards already operates normally.
//  E=0 at posedge: Q, cnt held; DONE driven 0.
//  E=1 at posedge, by MODE:
//   000 HOLD    Q unchanged
//   001 LOAD    Q <= D
//   010 SHL     Q <= {Q[WIDTH-2:0], SI_R}
//   011 SHR     Q <= {SI_L, Q[WIDTH-1:1]}
//   100 ROL     Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}
//   101 ROR     Q <= {Q[0], Q[WIDTH-1:1]}
//   110 CLEAR   Q <= RESET_VAL (synchronous)
//   111 SER_IN  SHR with SI_L; cnt <= cnt+1
//  Serial counter cnt: $clog2(WIDTH) bits, range 0..WIDTH-1.
//   SER_IN with cnt==WIDTH-1: shift performed, cnt <= 0, DONE <= 1 (registered: high the cycle after the WIDTH-th shift, Q then holds the full word, first bit in LSB).
//   E=1 and MODE != SER_IN: cnt <= 0 (partial word discarded, no DONE).
//   E=0 mid-word: cnt frozen, word resumes when E returns with SER_IN.
//   DONE is high for exactly one cycle; back-to-back words give DONE every WIDTH cycles with no gap.
//  Reset asserted mid-word: cnt=0, DONE=0, partial data lost.
//  No X propagation: undefined MODE codes do not exist (3-bit fully decoded).
// STRUCTURE
//  Mode encodings as localparams in shared header shift_reg_defs.vh (MODE_HOLD..MODE_SER_IN), reused by bench and PISO/SIPO users.
//  Single always block for Q/cnt/DONE with async reset; Qbar, SO_L, SO_R continuous assigns.
//  No sub-module: a per-bit cell would hide the shift wiring; keep flat.
// TESTING (WIDTH=8, RESET_VAL=8'h00 unless stated)
//  1 Reset: drive rst_n=0 between edges -> Q=00, Qbar=FF, DONE=0 without waiting for clk; release, LOAD D=A5 -> Q=A5, Qbar=5A.
//  2 Shift/rotate: Q=81; SHL SI_R=0 -> 02; ROR -> 01; ROR -> 80; ROL -> 01; SHR SI_L=1 -> 80; E=0 with MODE=LOAD D=FF -> 80 held.
//  3 Serial word: SER_IN 8 cycles SI_L=1,0,1,1,0,0,1,0 -> Q=4D, DONE=1 exactly the cycle after 8th edge, 0 before/after.
//  4 Interrupted word: 3 SER_IN bits, 1 cycle HOLD, 8 SER_IN bits -> DONE only after the 8 fresh bits; with E=0 gap instead of HOLD -> DONE after 5 more bits.
//  5 Back-to-back: 16 consecutive SER_IN cycles -> DONE pulses on cycles 9 and 17, Q correct at each.
//  6 RESET_VAL=8'h3C: async reset -> 3C; LOAD 00 then CLEAR -> 3C; reset mid-word (cnt=5) -> cnt=0, next DONE after 8 full bits.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// Mode codes are reused by the bench and by PISO/SIPO wrappers.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_LOAD   = 3'b001;
  localparam logic [2:0] MODE_SHL    = 3'b010;
  localparam logic [2:0] MODE_SHR    = 3'b011;
  localparam logic [2:0] MODE_ROL    = 3'b100;
  localparam logic [2:0] MODE_ROR    = 3'b101;
  localparam logic [2:0] MODE_CLEAR  = 3'b110;
  localparam logic [2:0] MODE_SER_IN = 3'b111;

endpackage

// File: rtl/univ_shift_reg.sv
// WIDTH-bit multi-mode register: hold/load/shift/rotate/clear
// plus counted serial-in with a registered word-complete pulse.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_L,
  input  logic             SI_R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             SO_L,
  output logic             SO_R,
  output logic             DONE
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  // Any enabled non-serial op discards a partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= RESET_VAL;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (!E) begin
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= '0;
      unique case (MODE)
        MODE_HOLD:  r_q <= r_q;
        MODE_LOAD:  r_q <= D;
        MODE_SHL:   r_q <= {r_q[WIDTH-2:0], SI_R};
        MODE_SHR:   r_q <= {SI_L, r_q[WIDTH-1:1]};
        MODE_ROL:   r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_ROR:   r_q <= {r_q[0], r_q[WIDTH-1:1]};
        MODE_CLEAR: r_q <= RESET_VAL;
        MODE_SER_IN: begin
          r_q <= {SI_L, r_q[WIDTH-1:1]};
          if (r_cnt == CNT_LAST) begin
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign Q    = r_q;
  assign Qbar = ~r_q;
  assign SO_L = r_q[WIDTH-1];
  assign SO_R = r_q[0];
  assign DONE = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8).
// Two instances: RESET_VAL=00 and RESET_VAL=3C, same stimulus.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       E;
  logic [2:0] MODE;
  logic [7:0] D;
  logic       SI_L;
  logic       SI_R;

  logic [7:0] q0, qb0, q1, qb1;
  logic       sol0, sor0, done0;
  logic       sol1, sor1, done1;

  int n_pass;
  int n_total;

  // behavioural model
  logic [7:0] m_q0, m_q1;
  int         m_bits;
  logic       m_done;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .E(E), .MODE(MODE), .D(D),
    .SI_L(SI_L), .SI_R(SI_R), .Q(q0), .Qbar(qb0),
    .SO_L(sol0), .SO_R(sor0), .DONE(done0)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h3C)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .E(E), .MODE(MODE), .D(D),
    .SI_L(SI_L), .SI_R(SI_R), .Q(q1), .Qbar(qb1),
    .SO_L(sol1), .SO_R(sor1), .DONE(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] nxt(
    input logic [7:0] q, input logic [2:0] md,
    input logic [7:0] d, input logic sl, input logic sr,
    input logic [7:0] rv
  );
    int v;
    v = int'(q);
    case (md)
      MODE_LOAD:   v = int'(d);
      MODE_SHL:    v = ((v * 2) + int'(sr)) % 256;
      MODE_SHR:    v = (v / 2) + 128 * int'(sl);
      MODE_ROL:    v = ((v * 2) % 256) + (v / 128);
      MODE_ROR:    v = (v / 2) + 128 * (v % 2);
      MODE_CLEAR:  v = int'(rv);
      MODE_SER_IN: v = (v / 2) + 128 * int'(sl);
      default:     v = int'(q);
    endcase
    return 8'(v);
  endfunction

  task automatic model_reset();
    m_q0   = 8'h00;
    m_q1   = 8'h3C;
    m_bits = 0;
    m_done = 1'b0;
  endtask

  // one clock: drive, edge, update model, leave outputs settled
  task automatic cyc(
    input logic e, input logic [2:0] md,
    input logic [7:0] d, input logic sl, input logic sr
  );
    E = e; MODE = md; D = d; SI_L = sl; SI_R = sr;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (e) begin
      m_q0 = nxt(m_q0, md, d, sl, sr, 8'h00);
      m_q1 = nxt(m_q1, md, d, sl, sr, 8'h3C);
      if (md == MODE_SER_IN) begin
        m_bits++;
        if (m_bits == 8) begin
          m_done = 1'b1;
          m_bits = 0;
        end
      end else begin
        m_bits = 0;
      end
    end
  endtask

  task automatic test_reset();
    cyc(1'b1, MODE_LOAD, 8'h77, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    n_total++;
    if (q0 !== 8'h00 || qb0 !== 8'hFF || done0 !== 1'b0)
      $display("FAIL reset_async0 q=%h qb=%h done=%b want 00 FF 0",
               q0, qb0, done0);
    else n_pass++;
    n_total++;
    if (q1 !== 8'h3C || qb1 !== 8'hC3 || done1 !== 1'b0)
      $display("FAIL reset_async1 q=%h qb=%h done=%b want 3C C3 0",
               q1, qb1, done1);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
    n_total++;
    if (q0 !== 8'hA5 || qb0 !== 8'h5A)
      $display("FAIL reset_load q=%h qb=%h want A5 5A", q0, qb0);
    else n_pass++;
  endtask

  task automatic test_shift_rotate();
    logic [2:0] md [7];
    logic       sl [7];
    logic       sr [7];
    logic       en [7];
    logic [7:0] d  [7];
    logic [7:0] exp_q [7];
    md = '{MODE_LOAD, MODE_SHL, MODE_ROR, MODE_ROR,
           MODE_ROL, MODE_SHR, MODE_LOAD};
    sl = '{0, 0, 0, 0, 0, 1, 0};
    sr = '{0, 0, 0, 0, 0, 0, 0};
    en = '{1, 1, 1, 1, 1, 1, 0};
    d  = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    exp_q = '{8'h81, 8'h02, 8'h01, 8'h80, 8'h01, 8'h80, 8'h80};
    for (int i = 0; i < 7; i++) begin
      cyc(en[i], md[i], d[i], sl[i], sr[i]);
      n_total++;
      if (q0 !== exp_q[i] || qb0 !== ~exp_q[i] ||
          sol0 !== exp_q[i][7] || sor0 !== exp_q[i][0])
        $display("FAIL shift_step%0d q=%h qb=%h so=%b%b want %h",
                 i, q0, qb0, sol0, sor0, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_serial_word();
    logic b [8];
    b = '{1, 0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, MODE_SER_IN, 8'h00, b[i], 1'b0);
      n_total++;
      if (done0 !== (i == 7))
        $display("FAIL ser_done%0d done=%b want %b", i, done0, i == 7);
      else n_pass++;
    end
    n_total++;
    if (q0 !== 8'h4D)
      $display("FAIL ser_word q=%h want 4D", q0);
    else n_pass++;
    cyc(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
    n_total++;
    if (done0 !== 1'b0 || q0 !== 8'h4D)
      $display("FAIL ser_after done=%b q=%h want 0 4D", done0, q0);
    else n_pass++;
  endtask

  task automatic test_interrupted();
    int cnt_done;
    int last;
    // HOLD discards the 3 partial bits
    cnt_done = 0; last = -1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, MODE_SER_IN, 8'h00, 1'($urandom), 1'b0);
      if (done0) cnt_done++;
    end
    cyc(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
    if (done0) cnt_done++;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, MODE_SER_IN, 8'h00, 1'($urandom), 1'b0);
      if (done0) begin cnt_done++; last = i; end
    end
    n_total++;
    if (cnt_done !== 1 || last !== 7 || q0 !== m_q0)
      $display("FAIL intr_hold pulses=%0d at=%0d q=%h want 1 7 %h",
               cnt_done, last, q0, m_q0);
    else n_pass++;
    // E=0 freezes the count
    cnt_done = 0; last = -1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, MODE_SER_IN, 8'h00, 1'($urandom), 1'b0);
      if (done0) cnt_done++;
    end
    cyc(1'b0, MODE_SER_IN, 8'h00, 1'b1, 1'b0);
    if (done0) cnt_done++;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, MODE_SER_IN, 8'h00, 1'($urandom), 1'b0);
      if (done0) begin cnt_done++; last = i; end
    end
    n_total++;
    if (cnt_done !== 1 || last !== 4 || q0 !== m_q0)
      $display("FAIL intr_gap pulses=%0d at=%0d q=%h want 1 4 %h",
               cnt_done, last, q0, m_q0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic       bits [$];
    logic [7:0] word;
    cyc(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      logic b;
      b = 1'($urandom);
      bits.push_back(b);
      cyc(1'b1, MODE_SER_IN, 8'h00, b, 1'b0);
      n_total++;
      if (done0 !== ((i % 8) == 0))
        $display("FAIL b2b_done%0d done=%b want %b",
                 i, done0, (i % 8) == 0);
      else n_pass++;
      if ((i % 8) == 0) begin
        word = '0;
        for (int k = 0; k < 8; k++) word[k] = bits[bits.size() - 8 + k];
        n_total++;
        if (q0 !== word)
          $display("FAIL b2b_word%0d q=%h want %h", i, q0, word);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_val();
    int cnt_done;
    int last;
    cyc(1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, MODE_CLEAR, 8'h00, 1'b0, 1'b0);
    n_total++;
    if (q1 !== 8'h3C || qb1 !== 8'hC3 || q0 !== 8'h00)
      $display("FAIL clear q1=%h qb1=%h q0=%h want 3C C3 00",
               q1, qb1, q0);
    else n_pass++;
    for (int i = 0; i < 5; i++)
      cyc(1'b1, MODE_SER_IN, 8'h00, 1'($urandom), 1'b0);
    rst_n = 1'b0;
    #2;
    n_total++;
    if (q1 !== 8'h3C || done1 !== 1'b0)
      $display("FAIL midword_rst q=%h done=%b want 3C 0", q1, done1);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0; last = -1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, MODE_SER_IN, 8'h00, 1'($urandom), 1'b0);
      if (done1) begin cnt_done++; last = i; end
    end
    n_total++;
    if (cnt_done !== 1 || last !== 7 || q1 !== m_q1)
      $display("FAIL midword_resume pulses=%0d at=%0d q=%h want 1 7 %h",
               cnt_done, last, q1, m_q1);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      logic [2:0] md;
      md = ($urandom_range(0, 2) == 0) ? 3'($urandom) : MODE_SER_IN;
      cyc(1'($urandom_range(0, 5) != 0), md, 8'($urandom),
          1'($urandom), 1'($urandom));
      n_total++;
      if (q0 !== m_q0 || qb0 !== ~m_q0 || sol0 !== m_q0[7] ||
          sor0 !== m_q0[0] || done0 !== m_done ||
          q1 !== m_q1 || qb1 !== ~m_q1 || sol1 !== m_q1[7] ||
          sor1 !== m_q1[0] || done1 !== m_done) begin
        if (errs < 10)
          $display("FAIL rand%0d q0=%h d0=%b q1=%h d1=%b want %h %b %h",
                   i, q0, done0, q1, done1, m_q0, m_done, m_q1);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; E = 1'b0; MODE = MODE_HOLD;
    D = 8'h00; SI_L = 1'b0; SI_R = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
    test_reset();
    test_shift_rotate();
    test_serial_word();
    test_interrupted();
    test_back_to_back();
    test_reset_val();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
